// File: rtl/chi_irq_pcie_pkg.sv
`default_nettype none
// ============================================================================
// Module  : chi_irq_pcie_pkg
// Purpose : Shared types and constants for the CHI interrupt -> PCIe
//           user-interrupt generator (FSM state encoding, timeout default).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package chi_irq_pcie_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_REQ_ASSERT   = 3'd1,
    ST_ACTIVE       = 3'd2,
    ST_REQ_DEASSERT = 3'd3,
    ST_HOLDOFF      = 3'd4
  } state_t;

  localparam int TIMEOUT_DEFAULT = 4096;

  // True in the two states that wait for usr_irq_ack from the PCIe core.
  function automatic logic is_req_state(input state_t s);
    return (s == ST_REQ_ASSERT) || (s == ST_REQ_DEASSERT);
  endfunction

endpackage : chi_irq_pcie_pkg
`default_nettype wire

// File: rtl/chi_irq_timer.sv
`default_nettype none
// ============================================================================
// Module  : chi_irq_timer
// Purpose : Loadable down-counter that saturates at zero.
// Ports   : clk, resetn      - clock, async active-low reset
//           load, load_val   - load count (load wins over dec)
//           dec              - decrement by one unless already zero
//           count, zero      - current count and count==0 flag
// Revision: 1.0 - initial release
// ============================================================================
module chi_irq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule : chi_irq_timer
`default_nettype wire

// File: rtl/chi_irq_pcie_gen.sv
`default_nettype none
// ============================================================================
// Module  : chi_irq_pcie_gen
// Purpose : Converts the interrupt handler's level irq into a PCIe
//           usr_irq_req/usr_irq_ack handshake, returns one-cycle irq_ack
//           pulses per completed assert/deassert handshake, and provides a
//           programmable hold-off, an ack timeout flag, a spurious-ack flag
//           and a wrapping interrupt counter.
// Ports   : clk, resetn         - clock, async active-low reset
//           irq_in, irq_ack     - level irq in, one-cycle completion pulse out
//           enable              - gate for starting new interrupts
//           holdoff_cycles      - idle cycles after deassert completes (0=none)
//           usr_irq_req/ack     - PCIe core handshake
//           timeout_err         - sticky ack-timeout flag
//           spurious_ack        - sticky ack-outside-request flag
//           err_clear           - clears both sticky flags (set wins)
//           irq_count           - completed assert handshakes, wraps
//           state_dbg           - current FSM state
// Revision: 1.0 - initial release
// ============================================================================
module chi_irq_pcie_gen
  import chi_irq_pcie_pkg::*;
#(
  parameter int HOLDOFF_W      = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 irq_in,
  output logic                 irq_ack,
  input  logic                 enable,
  input  logic [HOLDOFF_W-1:0] holdoff_cycles,
  output logic                 usr_irq_req,
  input  logic                 usr_irq_ack,
  output logic                 timeout_err,
  output logic                 spurious_ack,
  input  logic                 err_clear,
  output logic [CNT_W-1:0]     irq_count,
  output logic [2:0]           state_dbg
);

  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

  state_t                state, state_nxt;
  logic                  req_nxt, ack_nxt;
  logic                  hold_load, hold_dec, hold_zero;
  logic                  tmo_load, tmo_dec, tmo_zero;
  logic [HOLDOFF_W-1:0]  hold_count;
  logic [TMO_W-1:0]      tmo_count;
  logic                  timeout_hit, spurious_hit, count_inc;

  chi_irq_timer #(.W(HOLDOFF_W)) u_holdoff_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (hold_load),
    .dec      (hold_dec),
    .load_val (holdoff_cycles),
    .count    (hold_count),
    .zero     (hold_zero)
  );

  chi_irq_timer #(.W(TMO_W)) u_timeout_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (tmo_load),
    .dec      (tmo_dec),
    .load_val (TMO_LOAD),
    .count    (tmo_count),
    .zero     (tmo_zero)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_load = 1'b0;
    tmo_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (irq_in && enable) begin
          state_nxt = ST_REQ_ASSERT;
          tmo_load  = 1'b1;
        end
      end
      ST_REQ_ASSERT: begin
        // The request is never retracted; only the ack moves us on.
        if (usr_irq_ack) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!irq_in) begin
          state_nxt = ST_REQ_DEASSERT;
          tmo_load  = 1'b1;
        end
      end
      ST_REQ_DEASSERT: begin
        if (usr_irq_ack) begin
          if (holdoff_cycles != '0) begin
            state_nxt = ST_HOLDOFF;
            hold_load = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_HOLDOFF: begin
        // Leaving on count==1 makes the hold-off last exactly the loaded
        // number of cycles; zero is only a guard.
        if (hold_zero || (hold_count == HOLDOFF_W'(1))) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    hold_dec = (state == ST_HOLDOFF);
    tmo_dec  = is_req_state(state) && !usr_irq_ack;

    req_nxt  = (state_nxt == ST_REQ_ASSERT) || (state_nxt == ST_ACTIVE);
    ack_nxt  = is_req_state(state) && usr_irq_ack;

    // Flag on the edge where the timeout counter goes 1 -> 0.
    timeout_hit  = tmo_dec && !tmo_zero && (tmo_count == TMO_W'(1));
    spurious_hit = usr_irq_ack && !is_req_state(state);
    count_inc    = (state == ST_REQ_ASSERT) && usr_irq_ack;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      usr_irq_req  <= 1'b0;
      irq_ack      <= 1'b0;
      irq_count    <= '0;
      timeout_err  <= 1'b0;
      spurious_ack <= 1'b0;
    end else begin
      usr_irq_req <= req_nxt;
      irq_ack     <= ack_nxt;
      if (count_inc) irq_count <= irq_count + CNT_W'(1);

      if (timeout_hit)    timeout_err <= 1'b1;
      else if (err_clear) timeout_err <= 1'b0;

      if (spurious_hit)   spurious_ack <= 1'b1;
      else if (err_clear) spurious_ack <= 1'b0;
    end
  end

  assign state_dbg = state;

endmodule : chi_irq_pcie_gen
`default_nettype wire

// File: tb/tb_chi_irq_pcie_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_chi_irq_pcie_gen
// Purpose : Self-checking bench for chi_irq_pcie_gen: directed scenarios
//           followed by randomized traffic, all compared every cycle
//           against a transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_chi_irq_pcie_gen;

  localparam int HW  = 16;
  localparam int TMO = 16;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          irq_in = 1'b0;
  logic          enable = 1'b0;
  logic [HW-1:0] holdoff_cycles = '0;
  logic          usr_irq_ack = 1'b0;
  logic          err_clear = 1'b0;
  logic          irq_ack, usr_irq_req, timeout_err, spurious_ack;
  logic [CW-1:0] irq_count;
  logic [2:0]    state_dbg;

  chi_irq_pcie_gen #(
    .HOLDOFF_W      (HW),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .irq_in         (irq_in),
    .irq_ack        (irq_ack),
    .enable         (enable),
    .holdoff_cycles (holdoff_cycles),
    .usr_irq_req    (usr_irq_req),
    .usr_irq_ack    (usr_irq_ack),
    .timeout_err    (timeout_err),
    .spurious_ack   (spurious_ack),
    .err_clear      (err_clear),
    .irq_count      (irq_count),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: tracks the handshake as a transaction (busy / waiting
  // for PCIe ack / request level) with cycle stamps instead of counters.
  int e = 0;          // index of last clock edge
  bit m_busy, m_req, m_wait, m_ackp, m_tmo, m_spur;
  int m_wstart, m_qend, m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int m_state();
    if (m_busy) return m_wait ? (m_req ? 1 : 3) : 2;
    return (e < m_qend - 1) ? 4 : 0;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_req = 0; m_wait = 0; m_ackp = 0; m_tmo = 0; m_spur = 0;
    m_wstart = 0; m_qend = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit st, ss;
    e++;
    st = 0; ss = 0; m_ackp = 0;
    if (!m_busy) begin
      if (usr_irq_ack) ss = 1;
      if (e >= m_qend && irq_in && enable) begin
        m_busy = 1; m_req = 1; m_wait = 1; m_wstart = e;
      end
    end else if (m_wait) begin
      if (usr_irq_ack) begin
        m_ackp = 1;
        m_wait = 0;
        if (m_req) m_cnt = (m_cnt + 1) % (1 << CW);
        else begin
          m_busy = 0;
          m_qend = e + int'(holdoff_cycles) + 1;
        end
      end else if (e - m_wstart == TMO) begin
        st = 1;
      end
    end else begin
      if (usr_irq_ack) ss = 1;
      if (!irq_in) begin
        m_req = 0; m_wait = 1; m_wstart = e;
      end
    end
    m_tmo  = st ? 1'b1 : (err_clear ? 1'b0 : m_tmo);
    m_spur = ss ? 1'b1 : (err_clear ? 1'b0 : m_spur);
  endtask

  task automatic check_all();
    check("usr_irq_req",  usr_irq_req,  m_req);
    check("irq_ack",      irq_ack,      m_ackp);
    check("irq_count",    irq_count,    m_cnt);
    check("timeout_err",  timeout_err,  m_tmo);
    check("spurious_ack", spurious_ack, m_spur);
    check("state_dbg",    state_dbg,    m_state());
  endtask

  // Called at a falling edge: drive inputs, predict the next rising edge,
  // then compare at the following falling edge.
  task automatic step(input bit irq, input bit en, input int hold, input bit uack, input bit clr);
    irq_in = irq; enable = en; holdoff_cycles = HW'(hold);
    usr_irq_ack = uack; err_clear = clr;
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Asserts reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2;
    resetn = 1'b0;
    model_clear();
    #1;
    check_all();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    bit r_irq;
    int rate;

    model_clear();
    do_reset();

    // Basic handshake: req one cycle after irq, ack 3 cycles later.
    step(1, 1, 0, 0, 0);
    check("basic_req_latency", usr_irq_req, 1);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    check("basic_ack1", irq_ack, 1);
    check("basic_cnt", irq_count, 1);
    step(0, 1, 0, 0, 0);
    check("basic_ack_single", irq_ack, 0);
    check("basic_req_drop", usr_irq_req, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    check("basic_ack2", irq_ack, 1);
    step(0, 1, 0, 0, 0);
    check("basic_idle", state_dbg, 0);

    // Hold-off of 10 with irq re-raised before deassert completes.
    step(1, 1, 10, 0, 0);
    step(1, 1, 10, 1, 0);
    step(0, 1, 10, 0, 0);
    step(1, 1, 10, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1, 1, (i == 3) ? 2 : 10, 0, 0);
      check("holdoff_quiet", usr_irq_req, 0);
    end
    step(1, 1, 10, 0, 0);
    check("holdoff_resume", usr_irq_req, 1);

    // Timeout: no ack for TMO cycles after request assertion.
    for (int i = 1; i < TMO; i++) step(1, 1, 0, 0, 0);
    check("tmo_not_yet", timeout_err, 0);
    step(1, 1, 0, 0, 0);
    check("tmo_set", timeout_err, 1);
    check("tmo_req_held", usr_irq_req, 1);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    check("tmo_late_ack", irq_ack, 1);
    step(1, 1, 0, 0, 1);
    check("tmo_clear", timeout_err, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);

    // Spurious ack in IDLE, then clear.
    step(0, 1, 0, 1, 0);
    check("spur_set", spurious_ack, 1);
    check("spur_state", state_dbg, 0);
    step(0, 1, 0, 0, 1);
    check("spur_clear", spurious_ack, 0);

    // Enable gating.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      check("en_blocked", usr_irq_req, 0);
    end
    step(1, 1, 0, 0, 0);
    check("en_release", usr_irq_req, 1);
    step(1, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);

    // Early irq drop before the assert ack.
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("early_req_held", usr_irq_req, 1);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    check("early_req_drop", usr_irq_req, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    check("early_idle", state_dbg, 0);

    // Reset while ACTIVE, then a fresh handshake.
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    check("rst_pre_active", state_dbg, 2);
    do_reset();
    check("rst_req", usr_irq_req, 0);
    step(1, 1, 0, 0, 0);
    check("rst_fresh_req", usr_irq_req, 1);

    // Randomized traffic; ack rate varies so timeouts also occur.
    r_irq = 1'b1;
    rate  = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(0, 2))
          0: rate = 3;
          1: rate = 30;
          default: rate = 60;
        endcase
      end
      if (c % 1000 == 999) do_reset();
      if ($urandom_range(0, 7) == 0) r_irq = ~r_irq;
      step(r_irq, ($urandom_range(0, 9) != 0), int'($urandom_range(0, 6)),
           ($urandom_range(0, 99) < rate), ($urandom_range(0, 31) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_chi_irq_pcie_gen
`default_nettype wire
